sram_like_data_responder: RTL and testbench

- Responder (slave) end of the SRAM-like data interface (req / addr_ok / data_ok) driven by the MEM/EX load-store path.
- Accepts requests into an in-order outstanding queue and backs them with a word-addressed on-chip data RAM.
- Returns one data_ok pulse per request after a fixed latency, with optional pseudo-random addr_ok back-pressure.
- Serves as the data-side memory for core bring-up and as the reference responder for MEM-stage verification.

---
 rtl/sram_like_data_responder_pkg.sv | 35 +++
 rtl/sram_like_data_responder_resp_fifo.sv | 108 ++++++++++
 rtl/sram_like_data_responder.sv | 118 +++++++++++
 tb/tb_sram_like_data_responder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_data_responder_pkg.sv
// rtl/sram_like_data_responder_pkg.sv - shared encodings and helpers for the SRAM-like data responder
//
// Purpose: transfer-size encodings, the response-entry bit layout and the LFSR
// step function. The responder and its response queue both import this package.
// Ports: none (package).

package sram_like_data_responder_pkg;

  // data_sram_size encodings. The responder does not act on them because
  // wstrb alone defines a store, but the master uses the same values.
  typedef enum logic [1:0] {
    SRAM_SIZE_B = 2'd0,
    SRAM_SIZE_H = 2'd1,
    SRAM_SIZE_W = 2'd2
  } sram_size_e;

  localparam int SRAM_DATA_W = 32;

  // Width of the per-entry countdown. It is at least 1 bit so that the
  // LATENCY = 1 configuration still has a legal (always zero) field.
  function automatic int sram_timer_w(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

  // Response entry layout: {wr, data[31:0], timer[TW-1:0]}.
  function automatic int sram_resp_len(input int timer_w);
    return 1 + SRAM_DATA_W + timer_w;
  endfunction

  // 16-bit Fibonacci LFSR with taps 16, 14, 13 and 11.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/sram_like_data_responder_resp_fifo.sv
// rtl/sram_like_data_responder_resp_fifo.sv - in-order response queue with per-entry countdown timers
//
// Purpose: a DEPTH-entry circular queue of outstanding responses. Each entry
// counts down from LATENCY-1 to 0. The head retires only after its own timer
// has expired, so a younger entry whose timer ends first waits behind the head.
// Ports:
//   clk_i, rst_ni     clock and asynchronous active-low reset
//   push_i            enqueue {push_wr_i, push_data_i} (ignored when full)
//   pop_i             dequeue the head (honoured only when head_done_o is 1)
//   head_done_o       head entry is valid and its timer is 0
//   head_wr_o         head entry came from a store
//   head_data_o       head entry data
//   count_o           number of occupied entries

module sram_like_resp_fifo
  import sram_like_data_responder_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   push_wr_i,
  input  logic [31:0]            push_data_i,
  input  logic                   pop_i,
  output logic                   head_done_o,
  output logic                   head_wr_o,
  output logic [31:0]            head_data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = sram_timer_w(LATENCY);
  localparam int RL = sram_resp_len(TW);
  localparam logic [TW-1:0] TIMER_INIT = TW'(LATENCY - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);

  logic [RL-1:0]    ent_q [DEPTH];
  logic [RL-1:0]    ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;

  assign head_done_o = vld_q[rptr_q] && (ent_q[rptr_q][TW-1:0] == '0);
  assign head_wr_o   = ent_q[rptr_q][RL-1];
  assign head_data_o = ent_q[rptr_q][TW +: 32];
  assign count_o     = cnt_q;

  assign push = push_i && (cnt_q != DEPTH_C);
  assign pop  = pop_i && head_done_o;

  always_comb begin
    ent_d  = ent_q;
    vld_d  = vld_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;

    // All live entries age together; a timer that reached 0 stays there.
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (ent_q[i][TW-1:0] != '0)) begin
        ent_d[i][TW-1:0] = ent_q[i][TW-1:0] - 1'b1;
      end
    end

    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + 1'b1;
    end

    // The write slot is never live here, so this cannot clash with the
    // ageing above.
    if (push) begin
      vld_d[wptr_q] = 1'b1;
      ent_d[wptr_q] = {push_wr_i, push_data_i, TIMER_INIT};
      wptr_d        = wptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ent_q  <= ent_d;
    end
  end

endmodule

// File: rtl/sram_like_data_responder.sv
// rtl/sram_like_data_responder.sv - SRAM-like data-side responder backed by an on-chip word RAM
//
// Purpose: accepts req/addr_ok handshakes into an in-order response queue and
// answers each one with a single data_ok pulse after LATENCY cycles. The
// pseudo-random addr_ok back-pressure is optional.
// Ports:
//   clk, resetn            clock and asynchronous active-low reset
//   data_sram_req          request valid
//   data_sram_wr           1 = store, 0 = load
//   data_sram_size         transfer size; ignored (wstrb defines stores)
//   data_sram_addr         byte address; word index is addr[AW+1:2]
//   data_sram_wstrb        store byte enables
//   data_sram_wdata        store data
//   data_sram_addr_ok      request accepted when req is also 1
//   data_sram_data_ok      oldest outstanding request completes
//   data_sram_rdata        load data while data_ok is 1, else 0

module sram_like_data_responder
  import sram_like_data_responder_pkg::*;
#(
  parameter int          AW         = 10,
  parameter int          DEPTH      = 4,
  parameter int          LATENCY    = 2,
  parameter bit          RAND_STALL = 1'b0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   mem [0:(1 << AW) - 1];
  logic [AW-1:0] idx;
  logic          hs;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          addr_ok_q, addr_ok_d;
  logic [CW-1:0] cnt, cnt_next;
  logic          head_done, head_wr;
  logic [31:0]   head_data;
  logic [31:0]   push_data;
  logic          unused_bits;

  assign unused_bits = ^{data_sram_size, data_sram_addr};

  assign idx = data_sram_addr[AW+1:2];
  assign hs  = data_sram_req && addr_ok_q;

  // A load samples the word before this edge's write. Stores therefore reach
  // later loads, and an in-flight load keeps the value it already captured.
  assign push_data = data_sram_wr ? 32'h0 : mem[idx];

  always_ff @(posedge clk) begin
    if (hs && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) begin
          mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  sram_like_resp_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_resp_fifo (
    .clk_i       (clk),
    .rst_ni      (resetn),
    .push_i      (hs),
    .push_wr_i   (data_sram_wr),
    .push_data_i (push_data),
    .pop_i       (head_done),
    .head_done_o (head_done),
    .head_wr_o   (head_wr),
    .head_data_o (head_data),
    .count_o     (cnt)
  );

  // addr_ok is registered from the next-cycle occupancy and LFSR value, so
  // during a cycle it equals (count < DEPTH) & ~stall for that cycle's state.
  // This also holds it low for the whole cycle when the queue is full, even
  // if the head pops in that cycle.
  always_comb begin
    lfsr_d = lfsr16_next(lfsr_q);
    case ({hs, head_done})
      2'b10:   cnt_next = cnt + 1'b1;
      2'b01:   cnt_next = cnt - 1'b1;
      default: cnt_next = cnt;
    endcase
    addr_ok_d = (cnt_next < DEPTH_C) && !(RAND_STALL && lfsr_d[0]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q    <= LFSR_SEED;
      addr_ok_q <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      addr_ok_q <= addr_ok_d;
    end
  end

  assign data_sram_addr_ok = addr_ok_q;
  assign data_sram_data_ok = head_done;
  assign data_sram_rdata   = (head_done && !head_wr) ? head_data : 32'h0;

endmodule

// File: tb/tb_sram_like_data_responder.sv
// tb/tb_sram_like_data_responder.sv - self-checking bench for sram_like_data_responder

module tb_sram_like_data_responder;

  localparam int NI  = 4;
  localparam int DEP = 4;
  localparam int LAT   [NI] = '{2, 8, 1, 3};
  localparam bit STALL [NI] = '{1'b0, 1'b0, 1'b0, 1'b1};

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } rq_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'h0;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] wdata = 32'h0;
  int          sel = 0;

  logic [NI-1:0] aok, dok;
  logic [31:0]   rd [NI];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int gap_pct = 0;
  int stall_seen = 0;

  rq_t         reqq [$];
  rq_t         pend;
  bit          pend_v = 1'b0;
  exp_t        q [$];
  logic [31:0] mem_m [int];
  int          acc_cycles [$];
  int          dok_cycles [$];
  logic [31:0] last_rd = 32'h0;

  sram_like_data_responder #(.DEPTH(DEP), .LATENCY(2), .RAND_STALL(1'b0)) u_a (
    .clk(clk), .resetn(resetn), .data_sram_req(req && sel == 0), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb), .data_sram_wdata(wdata),
    .data_sram_addr_ok(aok[0]), .data_sram_data_ok(dok[0]), .data_sram_rdata(rd[0]));
  sram_like_data_responder #(.DEPTH(DEP), .LATENCY(8), .RAND_STALL(1'b0)) u_b (
    .clk(clk), .resetn(resetn), .data_sram_req(req && sel == 1), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb), .data_sram_wdata(wdata),
    .data_sram_addr_ok(aok[1]), .data_sram_data_ok(dok[1]), .data_sram_rdata(rd[1]));
  sram_like_data_responder #(.DEPTH(DEP), .LATENCY(1), .RAND_STALL(1'b0)) u_c (
    .clk(clk), .resetn(resetn), .data_sram_req(req && sel == 2), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb), .data_sram_wdata(wdata),
    .data_sram_addr_ok(aok[2]), .data_sram_data_ok(dok[2]), .data_sram_rdata(rd[2]));
  sram_like_data_responder #(.DEPTH(DEP), .LATENCY(3), .RAND_STALL(1'b1)) u_d (
    .clk(clk), .resetn(resetn), .data_sram_req(req && sel == 3), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb), .data_sram_wdata(wdata),
    .data_sram_addr_ok(aok[3]), .data_sram_data_ok(dok[3]), .data_sram_rdata(rd[3]));

  function automatic void add(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    rq_t r;
    r.wr = w;
    r.size = 2'($urandom_range(2));
    r.addr = a;
    r.wstrb = s;
    r.wdata = d;
    reqq.push_back(r);
  endfunction

  // Reference: the RAM is an associative array of words per instance. A response
  // is due LATENCY cycles after its handshake, but never before the cycle after
  // the previous response, because responses retire one per cycle in order.
  function automatic void accept();
    exp_t        e;
    int          key;
    logic [31:0] w;
    key = sel * 4096 + int'(pend.addr[11:2]);
    w = mem_m.exists(key) ? mem_m[key] : 32'h0;
    e.data = 32'h0;
    if (pend.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (pend.wstrb[b]) w[8*b +: 8] = pend.wdata[8*b +: 8];
      end
      mem_m[key] = w;
    end else begin
      e.data = w;
    end
    e.due = cyc + LAT[sel];
    if (q.size() > 0 && q[$].due >= e.due) e.due = q[$].due + 1;
    q.push_back(e);
    acc_cycles.push_back(cyc);
  endfunction

  task automatic step();
    logic        exp_dok;
    logic [31:0] exp_rd;
    @(negedge clk);
    cyc++;
    exp_dok = (q.size() > 0) && (q[0].due == cyc);
    exp_rd = exp_dok ? q[0].data : 32'h0;
    vectors++;
    if (dok[sel] !== exp_dok) begin
      miscompares++;
      $display("FAIL data_ok inst%0d cyc%0d: got %b want %b", sel, cyc, dok[sel], exp_dok);
    end
    vectors++;
    if (rd[sel] !== exp_rd) begin
      miscompares++;
      $display("FAIL rdata inst%0d cyc%0d: got %h want %h", sel, cyc, rd[sel], exp_rd);
    end
    if (dok[sel] === 1'b1) begin
      last_rd = rd[sel];
      dok_cycles.push_back(cyc);
    end
    vectors++;
    if (!STALL[sel]) begin
      if (aok[sel] !== (q.size() < DEP)) begin
        miscompares++;
        $display("FAIL addr_ok inst%0d cyc%0d: got %b want %b", sel, cyc, aok[sel], q.size() < DEP);
      end
    end else begin
      if (aok[sel] === 1'b1 && q.size() >= DEP) begin
        miscompares++;
        $display("FAIL addr_ok_full inst%0d cyc%0d: got 1 want 0", sel, cyc);
      end
      if (aok[sel] === 1'b0 && q.size() < DEP) stall_seen++;
    end
    if (exp_dok) void'(q.pop_front());

    if (!pend_v && reqq.size() > 0 && $urandom_range(99) >= gap_pct) begin
      pend = reqq.pop_front();
      pend_v = 1'b1;
    end
    req = pend_v;
    if (pend_v) begin
      wr = pend.wr;
      size = pend.size;
      addr = pend.addr;
      wstrb = pend.wstrb;
      wdata = pend.wdata;
      if (aok[sel] === 1'b1) begin
        accept();
        pend_v = 1'b0;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((reqq.size() > 0 || pend_v || q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (reqq.size() > 0 || pend_v || q.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout inst%0d: got %0d left want 0", sel, reqq.size() + q.size() + int'(pend_v));
    end
    step();
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      vectors += 3;
      if (aok[i] !== 1'b0) begin miscompares++; $display("FAIL reset_addr_ok inst%0d: got %b want 0", i, aok[i]); end
      if (dok[i] !== 1'b0) begin miscompares++; $display("FAIL reset_data_ok inst%0d: got %b want 0", i, dok[i]); end
      if (rd[i] !== 32'h0) begin miscompares++; $display("FAIL reset_rdata inst%0d: got %h want 0", i, rd[i]); end
    end
    resetn = 1'b1;
  endtask

  task automatic test_load_store();
    int lat0, lat1;
    sel = 0;
    gap_pct = 0;
    acc_cycles.delete();
    dok_cycles.delete();
    add(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF);
    add(1'b0, 32'h10, 4'b0000, 32'h0);
    drain(50);
    lat0 = (acc_cycles.size() == 2 && dok_cycles.size() == 2) ? dok_cycles[0] - acc_cycles[0] : -1;
    lat1 = (acc_cycles.size() == 2 && dok_cycles.size() == 2) ? dok_cycles[1] - acc_cycles[0] : -1;
    vectors += 3;
    if (lat0 != 2) begin miscompares++; $display("FAIL store_latency: got %0d want 2", lat0); end
    if (lat1 != 3) begin miscompares++; $display("FAIL load_latency: got %0d want 3", lat1); end
    if (last_rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL word_load: got %h want deadbeef", last_rd); end
    add(1'b1, 32'h10, 4'b0100, 32'h00AB0000);
    add(1'b0, 32'h10, 4'b0000, 32'h0);
    drain(50);
    vectors++;
    if (last_rd !== 32'hDEABBEEF) begin miscompares++; $display("FAIL byte_store: got %h want deabbeef", last_rd); end
  endtask

  task automatic test_fill();
    int gap4, span;
    sel = 1;
    gap_pct = 0;
    for (int i = 0; i < 5; i++) add(1'b1, 32'h100 + 32'(4 * i), 4'hF, $urandom());
    drain(100);
    acc_cycles.delete();
    dok_cycles.delete();
    for (int i = 0; i < 5; i++) add(1'b0, 32'h100 + 32'(4 * i), 4'h0, 32'h0);
    drain(100);
    gap4 = (acc_cycles.size() == 5 && dok_cycles.size() == 5) ? acc_cycles[4] - dok_cycles[0] : -1;
    span = (acc_cycles.size() == 5) ? acc_cycles[3] - acc_cycles[0] : -1;
    vectors += 2;
    if (span != 3) begin miscompares++; $display("FAIL fill_first4: got %0d want 3", span); end
    if (gap4 != 1) begin miscompares++; $display("FAIL fill_fifth_accept: got %0d want 1", gap4); end
  endtask

  task automatic test_back_to_back();
    int span, ndok;
    sel = 2;
    gap_pct = 0;
    for (int i = 0; i < 16; i++) add(1'b1, 32'(4 * i), 4'hF, $urandom());
    drain(100);
    acc_cycles.delete();
    dok_cycles.delete();
    for (int i = 0; i < 16; i++) add(1'b0, 32'(4 * i), 4'h0, 32'h0);
    drain(100);
    ndok = dok_cycles.size();
    span = (ndok == 16 && acc_cycles.size() == 16) ? dok_cycles[15] - acc_cycles[0] : -1;
    vectors += 2;
    if (ndok != 16) begin miscompares++; $display("FAIL b2b_count: got %0d want 16", ndok); end
    if (span != 16) begin miscompares++; $display("FAIL b2b_span: got %0d want 16", span); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] v;
    int n;
    sel = 1;
    gap_pct = 0;
    v = $urandom();
    add(1'b1, 32'h200, 4'hF, v);
    drain(50);
    for (int i = 0; i < 3; i++) add(1'b0, 32'h200, 4'h0, 32'h0);
    dok_cycles.delete();
    n = 0;
    while (dok_cycles.size() == 0 && n < 30) begin
      step();
      n++;
    end
    vectors++;
    if (dok_cycles.size() == 0) begin miscompares++; $display("FAIL midflight_wait: got no data_ok want one"); end
    #1 resetn = 1'b0;
    #1;
    vectors += 3;
    if (dok[1] !== 1'b0) begin miscompares++; $display("FAIL async_data_ok: got %b want 0", dok[1]); end
    if (aok[1] !== 1'b0) begin miscompares++; $display("FAIL async_addr_ok: got %b want 0", aok[1]); end
    if (rd[1] !== 32'h0) begin miscompares++; $display("FAIL async_rdata: got %h want 0", rd[1]); end
    q.delete();
    reqq.delete();
    pend_v = 1'b0;
    req = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    dok_cycles.delete();
    repeat (12) step();
    vectors++;
    if (dok_cycles.size() != 0) begin miscompares++; $display("FAIL stale_data_ok: got %0d want 0", dok_cycles.size()); end
    add(1'b0, 32'h200, 4'h0, 32'h0);
    drain(50);
    vectors++;
    if (last_rd !== v) begin miscompares++; $display("FAIL ram_retained: got %h want %h", last_rd, v); end
  endtask

  task automatic test_random_stall();
    sel = 3;
    gap_pct = 0;
    for (int i = 0; i < 16; i++) add(1'b1, 32'h300 + 32'(4 * i), 4'hF, $urandom());
    drain(400);
    gap_pct = 30;
    stall_seen = 0;
    dok_cycles.delete();
    acc_cycles.delete();
    for (int i = 0; i < 200; i++)
      add(1'($urandom_range(1)), 32'h300 + 32'(4 * $urandom_range(15)), 4'($urandom_range(15)), $urandom());
    drain(5000);
    vectors += 2;
    if (dok_cycles.size() != acc_cycles.size()) begin
      miscompares++;
      $display("FAIL one_per_request: got %0d data_ok want %0d", dok_cycles.size(), acc_cycles.size());
    end
    if (stall_seen == 0) begin miscompares++; $display("FAIL rand_stall: got 0 stall cycles want >0"); end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_fill();
    test_back_to_back();
    test_reset_midflight();
    test_random_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
